// File: rtl/wbu_pipe.sv
// wbu_pipe: buffered writeback stage with load formatting, commit FIFO and retire counter; WBU_CSR_EN enables CSR writeback on wb_sel=3
module wbu_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [XLEN-1:0]           in_snpc,
  input  logic [XLEN-1:0]           in_alu_result,
  input  logic [XLEN-1:0]           in_load_data,
  input  logic [$clog2(XLEN/8)-1:0] in_addr_lo,
  input  logic [2:0]                in_load_fmt,
  input  logic [1:0]                in_wb_sel,
  input  logic [XLEN-1:0]           in_csr_rdata,
  input  logic [REG_AW-1:0]         in_rd,
  input  logic                      in_rf_wen,
  output logic                      commit_valid,
  input  logic                      commit_ready,
  output logic [XLEN-1:0]           commit_pc,
  output logic                      rf_wen,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  output logic [CNT_W-1:0]          retire_cnt
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] pc_d [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [REG_AW-1:0] rd_q [DEPTH];
  logic [REG_AW-1:0] rd_d [DEPTH];
  logic [DEPTH-1:0] wen_q, wen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic full, push, pop;
  logic [IW-1:0] head;
  logic [XLEN-1:0] lane, ld_val, sel3_val, wdata;

  assign full = (wp_q[IW-1:0] == rp_q[IW-1:0]) && (wp_q[IW] != rp_q[IW]);
  assign in_ready = !full;
  assign commit_valid = wp_q != rp_q;
  assign push = in_valid && in_ready;
  assign pop = commit_valid && commit_ready;
  assign head = rp_q[IW-1:0];
  assign commit_pc = pc_q[head];
  assign rf_waddr = rd_q[head];
  assign rf_wdata = data_q[head];
  assign rf_wen = pop && wen_q[head] && (rd_q[head] != '0) && !rst;
  assign retire_cnt = cnt_q;
  assign lane = in_load_data >> {in_addr_lo, 3'b000};

`ifdef WBU_CSR_EN
  assign sel3_val = in_csr_rdata;
`else
  logic csr_unused;
  assign csr_unused = ^in_csr_rdata;
  assign sel3_val = in_alu_result;
`endif

  // extend the selected load lane according to funct3
  always_comb begin
    ld_val = lane;
    case (in_load_fmt)
      3'b000: ld_val = XLEN'($signed(lane[7:0]));
      3'b001: ld_val = XLEN'($signed(lane[15:0]));
      3'b010: ld_val = (XLEN == 64) ? XLEN'($signed(lane[31:0])) : lane;
      3'b100: ld_val = XLEN'(lane[7:0]);
      3'b101: ld_val = XLEN'(lane[15:0]);
      3'b110: ld_val = (XLEN == 64) ? XLEN'(lane[31:0]) : lane;
      default: ld_val = lane;
    endcase
  end

  // writeback source select
  always_comb begin
    wdata = (in_wb_sel == 2'd1) ? ld_val :
            (in_wb_sel == 2'd2) ? in_snpc :
            (in_wb_sel == 2'd3) ? sel3_val : in_alu_result;
  end

  // next-state: FIFO write, pointer advance, retire counting
  always_comb begin
    pc_d = pc_q;
    data_d = data_q;
    rd_d = rd_q;
    wen_d = wen_q;
    if (push) begin
      pc_d[wp_q[IW-1:0]] = in_pc;
      data_d[wp_q[IW-1:0]] = wdata;
      rd_d[wp_q[IW-1:0]] = in_rd;
      wen_d[wp_q[IW-1:0]] = in_rf_wen;
    end
    wp_d = wp_q + PW'(push);
    rp_d = rp_q + PW'(pop);
    cnt_d = cnt_q + CNT_W'(pop);
  end

  // state registers; reset empties the queue and clears storage
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      wen_q <= '0;
      pc_q <= '{default: '0};
      data_q <= '{default: '0};
      rd_q <= '{default: '0};
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      wen_q <= wen_d;
      pc_q <= pc_d;
      data_q <= data_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: tb/tb_wbu_pipe.sv
// tb_wbu_pipe: table vectors, corner sequences and random traffic against a queue-based reference model
module tb_wbu_pipe;
  localparam int DEPTH = 2;
`ifdef WBU_CSR_EN
  localparam bit CSR_ON = 1'b1;
`else
  localparam bit CSR_ON = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_ready, in_rf_wen, commit_valid, commit_ready, rf_wen;
  logic [31:0] in_pc, in_snpc, in_alu_result, in_load_data, in_csr_rdata, commit_pc, rf_wdata;
  logic [1:0] in_addr_lo, in_wb_sel;
  logic [2:0] in_load_fmt;
  logic [4:0] in_rd, rf_waddr;
  logic [63:0] retire_cnt;

  wbu_pipe #(.XLEN(32), .REG_AW(5), .DEPTH(DEPTH), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_snpc(in_snpc), .in_alu_result(in_alu_result), .in_load_data(in_load_data),
    .in_addr_lo(in_addr_lo), .in_load_fmt(in_load_fmt), .in_wb_sel(in_wb_sel),
    .in_csr_rdata(in_csr_rdata), .in_rd(in_rd), .in_rf_wen(in_rf_wen),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire_cnt(retire_cnt)
  );

  typedef struct { logic [31:0] pc; logic [4:0] rd; logic wen; logic [31:0] wd; } ent_t;
  typedef struct {
    logic [2:0] fmt; logic [1:0] lo; logic [1:0] sel; logic [4:0] rd;
    logic [31:0] snpc; logic [31:0] alu; logic [31:0] csr; logic [31:0] exp; logic exp_wen;
  } vec_t;
  ent_t q[$];
  logic [63:0] mcnt;
  int checks = 0, errors = 0;
  vec_t tv[8];
  logic [31:0] exp_pc[3];

  function automatic logic [31:0] ref_wd(logic [1:0] sel, logic [2:0] fmt, logic [1:0] lo,
      logic [31:0] ld, logic [31:0] alu, logic [31:0] snpc, logic [31:0] csr);
    logic [31:0] lane, b, h;
    lane = ld >> (8 * lo);
    b = lane % 256;
    h = lane % 65536;
    if (sel == 0) return alu;
    if (sel == 2) return snpc;
    if (sel == 3) return CSR_ON ? csr : alu;
    case (fmt)
      3'd0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return lane;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    if (rst) chk("rst_rf_wen", {63'd0, rf_wen}, 64'd0);
    else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < DEPTH});
      chk("commit_valid", {63'd0, commit_valid}, {63'd0, q.size() > 0});
      chk("retire_cnt", retire_cnt, mcnt);
      if (q.size() > 0) begin
        chk("commit_pc", {32'd0, commit_pc}, {32'd0, q[0].pc});
        chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, q[0].rd});
        chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, q[0].wd});
        chk("rf_wen", {63'd0, rf_wen}, {63'd0, commit_ready && q[0].wen && q[0].rd != 0});
      end else chk("rf_wen_empty", {63'd0, rf_wen}, 64'd0);
    end
  endtask

  task automatic advance();
    bit pushd, popd;
    @(posedge clk);
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      pushd = in_valid && q.size() < DEPTH;
      popd = commit_ready && q.size() > 0;
      if (popd) begin
        void'(q.pop_front());
        mcnt++;
      end
      if (pushd) q.push_back('{in_pc, in_rd, in_rf_wen,
        ref_wd(in_wb_sel, in_load_fmt, in_addr_lo, in_load_data, in_alu_result, in_snpc, in_csr_rdata)});
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  initial begin
    int pops;
    tv[0] = '{3'd0, 2'd3, 2'd1, 5'd5, 32'h0, 32'h0, 32'h0, 32'hFFFFFF80, 1'b1};
    tv[1] = '{3'd4, 2'd2, 2'd1, 5'd5, 32'h0, 32'h0, 32'h0, 32'h000000FF, 1'b1};
    tv[2] = '{3'd1, 2'd2, 2'd1, 5'd5, 32'h0, 32'h0, 32'h0, 32'hFFFF80FF, 1'b1};
    tv[3] = '{3'd5, 2'd0, 2'd1, 5'd5, 32'h0, 32'h0, 32'h0, 32'h00007F01, 1'b1};
    tv[4] = '{3'd0, 2'd0, 2'd2, 5'd1, 32'h80000008, 32'h0, 32'h0, 32'h80000008, 1'b1};
    tv[5] = '{3'd0, 2'd0, 2'd2, 5'd0, 32'h80000008, 32'h0, 32'h0, 32'h80000008, 1'b0};
    tv[6] = '{3'd0, 2'd0, 2'd3, 5'd7, 32'h0, 32'h11, 32'h22, CSR_ON ? 32'h22 : 32'h11, 1'b1};
    tv[7] = '{3'd2, 2'd0, 2'd0, 5'd31, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b1};
    exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h108;
    mcnt = 0;
    rst = 1; in_valid = 1; commit_ready = 1; in_pc = 32'h4; in_snpc = 0; in_alu_result = 0;
    in_load_data = 32'h80FF7F01; in_csr_rdata = 0; in_addr_lo = 0; in_load_fmt = 0;
    in_wb_sel = 0; in_rd = 3; in_rf_wen = 1;
    #1;
    cyc(); cyc();
    rst = 0; in_valid = 0; commit_ready = 0;
    sample();
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("reset_retire_cnt", retire_cnt, 64'd0);
    chk("reset_commit_pc", {32'd0, commit_pc}, 64'd0);
    chk("reset_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("reset_rf_wdata", {32'd0, rf_wdata}, 64'd0);
    advance();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; commit_ready = 0; in_pc = 32'h1000 + 32'(i * 4);
      in_load_fmt = tv[i].fmt; in_addr_lo = tv[i].lo; in_wb_sel = tv[i].sel; in_rd = tv[i].rd;
      in_snpc = tv[i].snpc; in_alu_result = tv[i].alu; in_csr_rdata = tv[i].csr; in_rf_wen = 1;
      cyc();
      in_valid = 0; commit_ready = 1;
      sample();
      chk($sformatf("vec%0d_wdata", i), {32'd0, rf_wdata}, {32'd0, tv[i].exp});
      chk($sformatf("vec%0d_wen", i), {63'd0, rf_wen}, {63'd0, tv[i].exp_wen});
      advance();
    end
    chk("vec_retire_cnt", retire_cnt, 64'd8);
    in_valid = 1; commit_ready = 0; in_wb_sel = 0; in_pc = 32'h100; cyc();
    in_pc = 32'h104; cyc();
    in_pc = 32'h108;
    sample();
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    advance();
    commit_ready = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) in_valid = 0;
      sample();
      chk($sformatf("order%0d", k), {32'd0, commit_pc}, {32'd0, exp_pc[k]});
      advance();
    end
    in_valid = 0; commit_ready = 0; rst = 1; cyc(); rst = 0;
    in_valid = 1; commit_ready = 1; pops = 0;
    for (int i = 0; i < 100; i++) begin
      in_pc = $urandom; in_alu_result = $urandom; in_rd = 5'($urandom);
      sample();
      if (i > 0) chk("stream_no_bubble", {63'd0, commit_valid}, 64'd1);
      if (commit_valid) pops++;
      advance();
    end
    in_valid = 0; commit_ready = 0;
    sample();
    chk("stream_pops", 64'(pops), 64'd99);
    chk("stream_retire_cnt", retire_cnt, 64'd99);
    advance();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      in_valid = 1'($urandom); commit_ready = 1'($urandom);
      in_pc = $urandom; in_snpc = $urandom; in_alu_result = $urandom; in_csr_rdata = $urandom;
      in_load_data = $urandom; in_load_fmt = 3'($urandom); in_wb_sel = 2'($urandom);
      in_rd = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom); in_rf_wen = 1'($urandom);
      in_addr_lo = (in_load_fmt inside {3'd2, 3'd3, 3'd6, 3'd7}) ? 2'd0 : 2'($urandom);
      cyc();
    end
    rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
